dff_glitch_filter: RTL and testbench
====================================

DFF_GLITCH_FILTER -- requirements
Module: dff_glitch_filter

Interface
REQ-001 Parameter STABLE_CYCLES, default 8, is the number of consecutive cycles a new synchronized level must persist before it is accepted; legal range 2..255.
REQ-002 Parameter GCNT_W, default 8, is the width of the rejected-glitch counter.
REQ-003 Port c  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port din  input  1  raw, asynchronous, possibly bouncing level.
REQ-006 Port clr  input  1  synchronous clear of glitch_cnt.
REQ-007 Port q  output  1  filtered level; this is the d input of the downstream retiming flop.
REQ-008 Port rise  output  1  one-cycle pulse when q goes 0->1.
REQ-009 Port fall  output  1  one-cycle pulse when q goes 1->0.
REQ-010 Port glitch_cnt  output  GCNT_W  saturating count of rejected transitions.
REQ-011 Port busy  output  1  high while a candidate level is being qualified.

Function
REQ-012 din SHALL pass through a two-flop synchronizer (s1, s2) before any other logic observes it.
REQ-013 The FSM SHALL have two states, IDLE and QUAL; a counter cnt of width $clog2(STABLE_CYCLES+1) SHALL track qualification progress.
REQ-014 In IDLE with s2 == q: remain in IDLE, cnt = 0.
REQ-015 In IDLE with s2 != q: go to QUAL, cnt = 1.
REQ-016 In QUAL with s2 == q: return to IDLE, cnt = 0, and increment glitch_cnt.
REQ-017 In QUAL with s2 != q and cnt == STABLE_CYCLES-1: set q = s2, return to IDLE, cnt = 0.
REQ-018 In QUAL with s2 != q and cnt < STABLE_CYCLES-1: increment cnt.
REQ-019 A held step on din SHALL appear on q exactly STABLE_CYCLES+2 rising edges after the first edge that samples it into s1.
REQ-020 busy SHALL be 1 exactly when the state is QUAL.
REQ-021 glitch_cnt SHALL saturate at 2**GCNT_W-1 and never wrap.
REQ-022 clr SHALL set glitch_cnt to 0 on the next edge; clr coincident with a rejection SHALL yield 0.
REQ-023 All state SHALL be held in always_ff flops with no initial values, so that the block can be triplicated.

Reset
REQ-024 While rst = 1: s1, s2, q, cnt, rise, fall, busy and glitch_cnt SHALL be 0 and the state SHALL be IDLE, independent of c.
REQ-025 Reset asserted mid-qualification SHALL abandon the qualification; no q change and no glitch count SHALL result.
REQ-026 After rst deasserts with din = 1, q SHALL rise through normal qualification: STABLE_CYCLES+2 edges later, with a rise pulse.

Configuration
REQ-027 With macro DFF_GLITCH_FILTER_EDGE_EN defined:
- rise and fall SHALL be registered pulses, asserted in the same cycle that q changes, for exactly one cycle.
REQ-028 Without DFF_GLITCH_FILTER_EDGE_EN:
- rise and fall SHALL remain as ports, tied to constant 0.
- No edge-detect flops SHALL be present.

Structure
REQ-029 Package dff_glitch_filter_pkg SHALL hold:
- the state enum typedef (IDLE, QUAL);
- the default constants STABLE_CYCLES_DEF = 8 and GCNT_W_DEF = 8.
REQ-030 The synchronizer SHALL be sub-module dff_sync2 (ports c, rst, d, q), instantiated once.

Verification
REQ-031 Reset: rst = 1 for 3 cycles with din toggling -> q = 0, glitch_cnt = 0, busy = 0 throughout.
REQ-032 Clean step with STABLE_CYCLES = 8: din 0->1 held -> q = 1 on edge 10, rise high for exactly that cycle, glitch_cnt = 0.
REQ-033 Glitch: din = 1 for 4 cycles then 0 -> q stays 0, busy high 4 cycles, glitch_cnt = 1.
REQ-034 Saturation: with GCNT_W = 2, inject 5 glitches -> glitch_cnt reaches 3 and holds; clr with a glitch rejected the same cycle -> 0.
REQ-035 Mid-qualification reset: rst pulse at cnt = 5 -> q = 0, cnt = 0, glitch_cnt unchanged at 0; with din still 1, q rises 10 edges after rst release.
REQ-036 Macro off: repeat REQ-032 -> q timing identical, rise and fall constantly 0.

Source files
------------

// File: rtl/dff_glitch_filter_pkg.sv
// dff_glitch_filter_pkg: shared state type and default parameters for dff_glitch_filter
package dff_glitch_filter_pkg;
  typedef enum logic {IDLE = 1'b0, QUAL = 1'b1} state_t;
  localparam int STABLE_CYCLES_DEF = 8;
  localparam int GCNT_W_DEF = 8;
endpackage

// File: rtl/dff_sync2.sv
// dff_sync2: two-flop synchronizer for an asynchronous level
module dff_sync2 (
  input  logic c,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge c or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      q <= 1'b0;
    end else begin
      s1 <= d;
      q <= s1;
    end
endmodule

// File: rtl/dff_glitch_filter.sv
// dff_glitch_filter: synchronizes and debounces din, counting rejected glitches
// Define DFF_GLITCH_FILTER_EDGE_EN to get registered rise/fall pulses; otherwise they read 0.
module dff_glitch_filter
  import dff_glitch_filter_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int GCNT_W = GCNT_W_DEF
) (
  input  logic c,
  input  logic rst,
  input  logic din,
  input  logic clr,
  output logic q,
  output logic rise,
  output logic fall,
  output logic [GCNT_W-1:0] glitch_cnt,
  output logic busy
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic s2;
  logic reject;
  dff_sync2 u_sync (
    .c(c),
    .rst(rst),
    .d(din),
    .q(s2)
  );
  assign reject = (state == QUAL) && (s2 == q);
  always_ff @(posedge c or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= 1'b0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (s2 != q) begin
        state <= QUAL;
        cnt <= CW'(1);
        busy <= 1'b1;
      end
    end else if (s2 == q || cnt == LAST) begin
      q <= s2;
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  // clr wins over a same-cycle rejection
  always_ff @(posedge c or posedge rst)
    if (rst) glitch_cnt <= '0;
    else glitch_cnt <= clr ? '0 : (reject && glitch_cnt != '1) ? glitch_cnt + GCNT_W'(1) : glitch_cnt;
`ifdef DFF_GLITCH_FILTER_EDGE_EN
  logic accept;
  assign accept = (state == QUAL) && (s2 != q) && (cnt == LAST);
  always_ff @(posedge c or posedge rst)
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept && s2;
      fall <= accept && !s2;
    end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: tb/tb_dff_glitch_filter.sv
// tb_dff_glitch_filter: directed checks of dff_glitch_filter timing, glitch counting and reset
module tb_dff_glitch_filter;
`ifdef DFF_GLITCH_FILTER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  logic c = 1'b0, rst = 1'b0, din = 1'b0, clr = 1'b0, din2 = 1'b0, clr2 = 1'b0;
  logic q, rise, fall, busy, q2, rise2, fall2, busy2;
  logic [7:0] gc;
  logic [1:0] gc2;
  int n_cmp = 0, n_bad = 0;

  always #5 c = ~c;

  dff_glitch_filter dut (
    .c(c), .rst(rst), .din(din), .clr(clr),
    .q(q), .rise(rise), .fall(fall), .glitch_cnt(gc), .busy(busy)
  );
  dff_glitch_filter #(.STABLE_CYCLES(8), .GCNT_W(2)) dut2 (
    .c(c), .rst(rst), .din(din2), .clr(clr2),
    .q(q2), .rise(rise2), .fall(fall2), .glitch_cnt(gc2), .busy(busy2)
  );

  task automatic tick;
    @(posedge c);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({q, busy, gc} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_async q/busy/gc got %b/%b/%0d want 0/0/0", q, busy, gc);
    end
    for (int i = 0; i < 3; i++) begin
      din = ~din;
      din2 = ~din2;
      tick();
      n_cmp++;
      if ({q, busy, gc, rise, fall, q2, gc2} !== 15'd0) begin
        n_bad++;
        $display("FAIL reset_hold cyc%0d q=%b busy=%b gc=%0d rise=%b fall=%b q2=%b gc2=%0d want all 0",
                 i, q, busy, gc, rise, fall, q2, gc2);
      end
    end
    din = 1'b0;
    din2 = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({q, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_release q/busy got %b/%b want 0/0", q, busy);
    end
  endtask

  task automatic test_clean_step;
    din = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_cmp++;
      if (q !== (i >= 10) || busy !== (i >= 3 && i <= 9) || rise !== (EDGE && i == 10) || fall !== 1'b0) begin
        n_bad++;
        $display("FAIL step_up edge%0d q=%b busy=%b rise=%b fall=%b want %b %b %b 0",
                 i, q, busy, rise, fall, i >= 10, i >= 3 && i <= 9, EDGE && i == 10);
      end
    end
    din = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      n_cmp++;
      if (q !== (i < 10) || fall !== (EDGE && i == 10) || rise !== 1'b0) begin
        n_bad++;
        $display("FAIL step_down edge%0d q=%b fall=%b rise=%b want %b %b 0",
                 i, q, fall, rise, i < 10, EDGE && i == 10);
      end
    end
    n_cmp++;
    if (gc !== 8'd0) begin
      n_bad++;
      $display("FAIL step_gc got %0d want 0", gc);
    end
  endtask

  task automatic test_mid_reset;
    din = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (dut.cnt !== 4'd5 || busy !== 1'b1 || q !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_pre cnt=%0d busy=%b q=%b want 5 1 0", dut.cnt, busy, q);
    end
    rst = 1'b1;
    #2;
    n_cmp++;
    if (dut.cnt !== 4'd0 || busy !== 1'b0 || q !== 1'b0 || gc !== 8'd0 || rise !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_during cnt=%0d busy=%b q=%b gc=%0d rise=%b want 0 0 0 0 0", dut.cnt, busy, q, gc, rise);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if (q !== (i == 10) || rise !== (EDGE && i == 10) || gc !== 8'd0) begin
        n_bad++;
        $display("FAIL midrst_after edge%0d q=%b rise=%b gc=%0d want %b %b 0", i, q, rise, gc, i == 10, EDGE && i == 10);
      end
    end
    din = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (q !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_return q got %b want 0", q);
    end
  endtask

  task automatic test_glitch;
    int nb = 0;
    for (int i = 1; i <= 12; i++) begin
      din = (i <= 4);
      tick();
      if (busy) nb++;
      n_cmp++;
      if (q !== 1'b0 || rise !== 1'b0) begin
        n_bad++;
        $display("FAIL glitch_q edge%0d q=%b rise=%b want 0 0", i, q, rise);
      end
    end
    n_cmp++;
    if (nb != 4) begin
      n_bad++;
      $display("FAIL glitch_busy cycles got %0d want 4", nb);
    end
    n_cmp++;
    if (gc !== 8'd1) begin
      n_bad++;
      $display("FAIL glitch_cnt got %0d want 1", gc);
    end
  endtask

  task automatic test_saturation;
    for (int g = 1; g <= 5; g++) begin
      din2 = 1'b1;
      repeat (2) tick();
      din2 = 1'b0;
      repeat (4) tick();
      n_cmp++;
      if (gc2 !== 2'((g > 3) ? 3 : g) || q2 !== 1'b0) begin
        n_bad++;
        $display("FAIL sat glitch%0d gc2=%0d q2=%b want %0d 0", g, gc2, q2, (g > 3) ? 3 : g);
      end
    end
    din2 = 1'b1;
    repeat (2) tick();
    din2 = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (busy2 !== 1'b1 || gc2 !== 2'd3) begin
      n_bad++;
      $display("FAIL sat_pre_clr busy2=%b gc2=%0d want 1 3", busy2, gc2);
    end
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    n_cmp++;
    if (gc2 !== 2'd0 || busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clr_reject gc2=%0d busy2=%b want 0 0", gc2, busy2);
    end
    din2 = 1'b1;
    repeat (2) tick();
    din2 = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (gc2 !== 2'd1) begin
      n_bad++;
      $display("FAIL sat_after_clr gc2=%0d want 1", gc2);
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_mid_reset();
    test_glitch();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
